cl2_pl_exu_wbctrl: RTL and testbench

Write-back controller for the execute-stage integer register file. It arbitrates NUM_REQ write-back requesters (ALU, LSU, MDU) onto the regfile's single write port through one registered stage. It also keeps a per-register busy scoreboard that stalls issue on RAW and WAW hazards. It sits between the functional units and the regfile write port (wd_wen/wd_idx/wd_dat), and feeds the issue-stall logic.

---
 rtl/cl2_pl_exu_pkg.sv | 23 ++
 rtl/cl2_pl_exu_wbarb.sv | 35 +++
 rtl/cl2_pl_exu_wbctrl.sv | 72 +++++++
 tb/tb_cl2_pl_exu_wbctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/cl2_pl_exu_pkg.sv
// cl2_pl_exu_pkg: shared execute-stage types and constants for the write-back path.
`ifndef CL2_REGFILE_WIDTH
`define CL2_REGFILE_WIDTH 5
`endif
`ifndef CL2_XLEN
`define CL2_XLEN 32
`endif
`ifndef CL2_REGFILE_NUM
`define CL2_REGFILE_NUM 32
`endif
package cl2_pl_exu_pkg;
   localparam int NUM_WB_REQ = 3;
   localparam int WB_ALU     = 0;
   localparam int WB_LSU     = 1;
   localparam int WB_MDU     = 2;
   localparam int RF_W       = `CL2_REGFILE_WIDTH;
   localparam int XLEN       = `CL2_XLEN;
   localparam int RF_NUM     = `CL2_REGFILE_NUM;
   typedef struct packed {
      logic [RF_W-1:0] idx;
      logic [XLEN-1:0] dat;
   } wb_req_t;
endpackage

// File: rtl/cl2_pl_exu_wbarb.sv
// cl2_pl_exu_wbarb: one-hot write-back arbiter; round-robin with CL2_WB_RR_EN, else fixed lowest-index priority.
import cl2_pl_exu_pkg::*;
module cl2_pl_exu_wbarb #(
   parameter int N = NUM_WB_REQ
) (
`ifdef CL2_WB_RR_EN
   input  logic         clk_i,
   input  logic         rst_n_i,
`endif
   input  logic [N-1:0] req_i,
   output logic [N-1:0] gnt_o
);
`ifdef CL2_WB_RR_EN
   localparam int PW = N > 1 ? $clog2(N) : 1;
   logic [PW-1:0] ptr_q, ptr_d;
   int j;
   always_comb begin
      gnt_o = '0;
      ptr_d = ptr_q;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr_q) + i) % N;
         if (req_i[j] && gnt_o == '0) begin
            gnt_o[j] = 1'b1;
            ptr_d    = PW'((j + 1) % N);
         end
      end
   end
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) ptr_q <= '0;
      else          ptr_q <= ptr_d;
`else
   assign gnt_o = req_i & (~req_i + N'(1));
`endif
endmodule

// File: rtl/cl2_pl_exu_wbctrl.sv
// cl2_pl_exu_wbctrl: arbitrates functional-unit write-backs onto the regfile port and tracks busy registers.
// Arbitration policy selected by CL2_WB_RR_EN (round-robin) or fixed priority when undefined.
import cl2_pl_exu_pkg::*;
module cl2_pl_exu_wbctrl #(
   parameter int NUM_REQ = NUM_WB_REQ
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      iss_vld_i,
   output logic                      iss_rdy_o,
   input  logic                      iss_wr_i,
   input  logic [RF_W-1:0]           iss_rd_idx_i,
   input  logic [RF_W-1:0]           iss_rs1_idx_i,
   input  logic [RF_W-1:0]           iss_rs2_idx_i,
   output logic                      hazard_o,
   input  logic [NUM_REQ-1:0]        wb_vld_i,
   output logic [NUM_REQ-1:0]        wb_rdy_o,
   input  logic [NUM_REQ*RF_W-1:0]   wb_idx_i,
   input  logic [NUM_REQ*XLEN-1:0]   wb_dat_i,
   output logic                      rf_wen_o,
   output logic [RF_W-1:0]           rf_idx_o,
   output logic [XLEN-1:0]           rf_dat_o,
   output logic [RF_NUM-1:0]         busy_o
);
   wb_req_t           sel;
   logic              rf_wen_q, rf_wen_d;
   wb_req_t           rf_q;
   logic [RF_NUM-1:0] busy_q, busy_d;

   cl2_pl_exu_wbarb #(.N(NUM_REQ)) u_arb (
`ifdef CL2_WB_RR_EN
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
`endif
      .req_i   (wb_vld_i),
      .gnt_o   (wb_rdy_o)
   );

   // Grant is one-hot, so OR-ing the masked requests acts as the mux.
   always_comb begin
      sel = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (wb_rdy_o[k]) sel = sel | {wb_idx_i[k*RF_W +: RF_W], wb_dat_i[k*XLEN +: XLEN]};
   end

   assign hazard_o  = busy_q[iss_rs1_idx_i] | busy_q[iss_rs2_idx_i] | (iss_wr_i & busy_q[iss_rd_idx_i]);
   assign iss_rdy_o = iss_vld_i & ~hazard_o;
   assign rf_wen_d  = (|wb_rdy_o) & (|sel.idx);

   always_comb begin
      busy_d = busy_q;
      if (rf_wen_q) busy_d[rf_q.idx] = 1'b0;
      if (iss_rdy_o && iss_wr_i) busy_d[iss_rd_idx_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         rf_wen_q <= 1'b0;
         rf_q     <= '0;
         busy_q   <= '0;
      end else begin
         rf_wen_q <= rf_wen_d;
         if (|wb_rdy_o) rf_q <= sel;
         busy_q   <= busy_d;
      end

   assign rf_wen_o = rf_wen_q;
   assign rf_idx_o = rf_q.idx;
   assign rf_dat_o = rf_q.dat;
   assign busy_o   = busy_q;
endmodule

// File: tb/tb_cl2_pl_exu_wbctrl.sv
// tb_cl2_pl_exu_wbctrl: directed bench with a write-back scoreboard for cl2_pl_exu_wbctrl (either CL2_WB_RR_EN build).
import cl2_pl_exu_pkg::*;
module tb_cl2_pl_exu_wbctrl;
  localparam int N = NUM_WB_REQ;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              iss_vld = 1'b0, iss_rdy, iss_wr = 1'b0, hazard;
  logic [RF_W-1:0]   rd = '0, rs1 = '0, rs2 = '0;
  logic [N-1:0]      wb_vld = '0, wb_rdy;
  logic [N*RF_W-1:0] wb_idx = '0;
  logic [N*XLEN-1:0] wb_dat = '0;
  logic              rf_wen;
  logic [RF_W-1:0]   rf_idx;
  logic [XLEN-1:0]   rf_dat;
  logic [RF_NUM-1:0] busy;
  int                errors = 0, checks = 0;
  wb_req_t           exp_q[$];
  wb_req_t           got, want;
  cl2_pl_exu_wbctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .iss_vld_i(iss_vld), .iss_rdy_o(iss_rdy), .iss_wr_i(iss_wr),
    .iss_rd_idx_i(rd), .iss_rs1_idx_i(rs1), .iss_rs2_idx_i(rs2), .hazard_o(hazard),
    .wb_vld_i(wb_vld), .wb_rdy_o(wb_rdy), .wb_idx_i(wb_idx), .wb_dat_i(wb_dat),
    .rf_wen_o(rf_wen), .rf_idx_o(rf_idx), .rf_dat_o(rf_dat), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && rf_wen) begin
      got = '{idx: rf_idx, dat: rf_dat};
      if (exp_q.size() == 0) chk("rf_unexpected_write", got, wb_req_t'('0));
      else begin
        want = exp_q.pop_front();
        chk("rf_write", got, want);
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_wb(input int k, input logic [RF_W-1:0] idx, input logic [XLEN-1:0] dat);
    wb_idx[k*RF_W +: RF_W] = idx;
    wb_dat[k*XLEN +: XLEN] = dat;
  endtask
  task automatic issue(input logic v, input logic w, input logic [RF_W-1:0] d,
                       input logic [RF_W-1:0] s1, input logic [RF_W-1:0] s2);
    iss_vld = v; iss_wr = w; rd = d; rs1 = s1; rs2 = s2;
  endtask
  initial begin
    tick(); tick();
    chk("reset_rf_wen", rf_wen, 1'b0);
    chk("reset_rf_idx", rf_idx, '0);
    chk("reset_rf_dat", rf_dat, '0);
    chk("reset_busy", busy, '0);
    rst_n = 1'b1;
    tick();
    set_wb(WB_ALU, 5, 32'hDEADBEEF); wb_vld = 3'b001;
    exp_q.push_back('{idx: 5, dat: 32'hDEADBEEF});
    #1 chk("alu_grant", wb_rdy, 3'b001);
    tick(); wb_vld = '0;
    #1 chk("alu_rf_wen", rf_wen, 1'b1);
    chk("alu_rf_idx", rf_idx, 5'd5);
    chk("alu_rf_dat", rf_dat, 32'hDEADBEEF);
    chk("alu_busy_unchanged", busy, '0);
    issue(1, 1, 7, 0, 0);
    #1 chk("raw_first_rdy", iss_rdy, 1'b1);
    tick(); issue(1, 0, 0, 7, 0);
    #1 chk("raw_busy7", busy[7], 1'b1);
    chk("raw_hazard", hazard, 1'b1);
    chk("raw_stall_rdy", iss_rdy, 1'b0);
    set_wb(WB_MDU, 7, 32'h0000_0077); wb_vld = 3'b100;
    exp_q.push_back('{idx: 7, dat: 32'h77});
    #1 chk("mdu_grant", wb_rdy, 3'b100);
    tick(); wb_vld = '0;
    #1 chk("raw_clear_cycle_rf_wen", rf_wen, 1'b1);
    chk("raw_clear_cycle_hazard", hazard, 1'b1);
    tick();
    #1 chk("raw_after_busy7", busy[7], 1'b0);
    chk("raw_after_rdy", iss_rdy, 1'b1);
    issue(0, 0, 0, 0, 0);
    set_wb(WB_ALU, 10, 32'hA0A0_0001); set_wb(WB_LSU, 11, 32'hB0B0_0002); set_wb(WB_MDU, 12, 32'hC0C0_0003);
    wb_vld = 3'b111;
`ifdef CL2_WB_RR_EN
    exp_q.push_back('{idx: 10, dat: 32'hA0A0_0001});
    #1 chk("rr_grant0", wb_rdy, 3'b001);
    tick(); exp_q.push_back('{idx: 11, dat: 32'hB0B0_0002});
    #1 chk("rr_grant1", wb_rdy, 3'b010);
    tick(); exp_q.push_back('{idx: 12, dat: 32'hC0C0_0003});
    #1 chk("rr_grant2", wb_rdy, 3'b100);
    tick(); wb_vld = '0;
`else
    exp_q.push_back('{idx: 10, dat: 32'hA0A0_0001});
    #1 chk("fp_grant0", wb_rdy, 3'b001);
    tick(); exp_q.push_back('{idx: 10, dat: 32'hA0A0_0001});
    #1 chk("fp_grant1", wb_rdy, 3'b001);
    tick(); exp_q.push_back('{idx: 10, dat: 32'hA0A0_0001});
    #1 chk("fp_grant2", wb_rdy, 3'b001);
    tick(); wb_vld = 3'b110; exp_q.push_back('{idx: 11, dat: 32'hB0B0_0002});
    #1 chk("fp_grant_lsu", wb_rdy, 3'b010);
    tick(); wb_vld = 3'b100; exp_q.push_back('{idx: 12, dat: 32'hC0C0_0003});
    #1 chk("fp_grant_mdu", wb_rdy, 3'b100);
    tick(); wb_vld = '0;
`endif
    tick();
    set_wb(WB_LSU, 0, 32'h1234_5678); wb_vld = 3'b010;
    #1 chk("x0_grant", wb_rdy, 3'b010);
    tick(); wb_vld = '0;
    issue(1, 1, 0, 0, 0);
    #1 chk("x0_rf_wen", rf_wen, 1'b0);
    chk("x0_hazard", hazard, 1'b0);
    chk("x0_rdy", iss_rdy, 1'b1);
    tick(); issue(0, 0, 0, 0, 0);
    #1 chk("x0_busy", busy, '0);
    issue(1, 1, 3, 0, 0);
    tick(); issue(1, 1, 3, 0, 0);
    #1 chk("waw_busy3", busy[3], 1'b1);
    chk("waw_hazard", hazard, 1'b1);
    issue(1, 0, 3, 0, 0);
    #1 chk("nowr_hazard", hazard, 1'b0);
    chk("nowr_rdy", iss_rdy, 1'b1);
    tick(); issue(1, 1, 7, 0, 0);
    tick(); issue(0, 0, 0, 0, 0);
    set_wb(WB_ALU, 9, 32'h0000_0099); wb_vld = 3'b001;
    exp_q.push_back('{idx: 9, dat: 32'h99});
    tick(); wb_vld = '0;
    #1 chk("pre_reset_busy", busy, 32'h0000_0088);
    chk("pre_reset_rf_wen", rf_wen, 1'b1);
    @(negedge clk); #1 rst_n = 1'b0;
    #1 chk("async_reset_busy", busy, '0);
    chk("async_reset_rf_wen", rf_wen, 1'b0);
    tick(); rst_n = 1'b1;
    tick();
    chk("post_reset_rf_wen", rf_wen, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
